// File: rtl/sdcard_pkg.sv
// Shared definitions for the SD card SPI-mode command sequencer.
package sdcard_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CALC = 3'd1,
    SEND = 3'd2,
    HUNT = 3'd3,
    RESP = 3'd4,
    TAIL = 3'd5
  } state_t;

  localparam int         HUNT_MAX_DEF = 8;
  // x^7 + x^3 + 1 with the x^7 term implicit
  localparam logic [6:0] CRC7_POLY    = 7'h09;

endpackage

// File: rtl/sdcard_crc7.sv
// Serial CRC7 generator, one message bit per enabled clock, MSB first.
module sdcard_crc7
  import sdcard_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  logic fb;
  assign fb = din ^ crc[6];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   crc <= '0;
    else if (clr) crc <= '0;
    else if (en)  crc <= {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  end

endmodule

// File: rtl/sdcard_cmd.sv
// SD card SPI command sequencer: frames a command with CRC7, drives a byte
// engine through send / response hunt / extended response / trailing byte.
module sdcard_cmd
  import sdcard_pkg::*;
#(
  parameter int HUNT_MAX = HUNT_MAX_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic        cmd_long,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [7:0]  resp_r1,
  output logic [31:0] resp_ext,
  output logic        cs_n,
  output logic [7:0]  spi_data_in,
  output logic [4:0]  spi_bits,
  output logic        spi_start,
  input  logic        spi_finished,
  input  logic [7:0]  spi_data_out
);

  localparam int CW = ($clog2(HUNT_MAX + 1) > 6) ? $clog2(HUNT_MAX + 1) : 6;

  state_t        state;
  logic [5:0]    idx_q;
  logic [31:0]   arg_q;
  logic          long_q;
  logic [39:0]   frame;
  logic [CW-1:0] cnt;
  logic          pending;
  logic [6:0]    crc;
  logic [7:0]    send_byte;
  logic [7:0]    xfer_byte;

  assign busy = (state != IDLE);

  sdcard_crc7 u_crc7 (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state == IDLE && cmd_start),
    .en    (state == CALC),
    .din   (frame[39]),
    .crc   (crc)
  );

  always_comb begin
    send_byte = 8'hFF;
    case (cnt[2:0])
      3'd0:    send_byte = {2'b01, idx_q};
      3'd1:    send_byte = arg_q[31:24];
      3'd2:    send_byte = arg_q[23:16];
      3'd3:    send_byte = arg_q[15:8];
      3'd4:    send_byte = arg_q[7:0];
      3'd5:    send_byte = {crc, 1'b1};
      default: send_byte = 8'hFF;
    endcase
  end

  assign xfer_byte = (state == SEND) ? send_byte : 8'hFF;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cs_n        <= 1'b1;
      done        <= 1'b0;
      timeout     <= 1'b0;
      spi_start   <= 1'b0;
      spi_data_in <= 8'hFF;
      spi_bits    <= 5'd0;
      resp_r1     <= 8'hFF;
      resp_ext    <= 32'h0;
      cnt         <= '0;
      pending     <= 1'b0;
      idx_q       <= 6'd0;
      arg_q       <= 32'h0;
      long_q      <= 1'b0;
      frame       <= 40'h0;
    end else begin
      spi_start <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: if (cmd_start) begin
          idx_q    <= cmd_index;
          arg_q    <= cmd_arg;
          long_q   <= cmd_long;
          frame    <= {2'b01, cmd_index, cmd_arg};
          timeout  <= 1'b0;
          resp_r1  <= 8'hFF;
          resp_ext <= 32'h0;
          cnt      <= '0;
          cs_n     <= 1'b0;
          state    <= CALC;
        end
        CALC: begin
          frame <= {frame[38:0], 1'b0};
          if (cnt == CW'(39)) begin
            cnt   <= '0;
            state <= SEND;
          end else cnt <= cnt + 1'b1;
        end
        default: begin
          // Every remaining state is a sequence of engine transfers; a new
          // one is launched only once the previous finish has been consumed.
          if (!pending) begin
            spi_start   <= 1'b1;
            pending     <= 1'b1;
            spi_data_in <= xfer_byte;
            spi_bits    <= (state == HUNT) ? 5'd15 : 5'd7;
          end else if (spi_finished) begin
            pending <= 1'b0;
            case (state)
              SEND: begin
                if (cnt == CW'(5)) begin
                  cnt   <= '0;
                  state <= HUNT;
                end else cnt <= cnt + 1'b1;
              end
              HUNT: begin
                if (!spi_data_out[7]) begin
                  resp_r1 <= spi_data_out;
                  cnt     <= '0;
                  state   <= long_q ? RESP : TAIL;
                end else if (cnt == CW'(HUNT_MAX - 1)) begin
                  timeout <= 1'b1;
                  resp_r1 <= 8'hFF;
                  cnt     <= '0;
                  state   <= TAIL;
                end else cnt <= cnt + 1'b1;
              end
              RESP: begin
                resp_ext <= {resp_ext[23:0], spi_data_out};
                if (cnt == CW'(3)) begin
                  cnt   <= '0;
                  state <= TAIL;
                end else cnt <= cnt + 1'b1;
              end
              TAIL: begin
                cs_n  <= 1'b1;
                done  <= 1'b1;
                state <= IDLE;
              end
              default: state <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdcard_cmd.sv
// Randomized bench for sdcard_cmd: byte-engine + card model, transaction-level reference.
module tb_sdcard_cmd;

  localparam int HM = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_start = 1'b0;
  logic [5:0]  cmd_index = 6'd0;
  logic [31:0] cmd_arg = 32'h0;
  logic        cmd_long = 1'b0;
  logic        busy, done, timeout, cs_n, spi_start;
  logic [7:0]  resp_r1, spi_data_in;
  logic [31:0] resp_ext;
  logic [4:0]  spi_bits;
  logic        spi_finished = 1'b0;
  logic [7:0]  spi_data_out = 8'hFF;

  sdcard_cmd #(.HUNT_MAX(HM)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_start(cmd_start), .cmd_index(cmd_index),
    .cmd_arg(cmd_arg), .cmd_long(cmd_long), .busy(busy), .done(done),
    .timeout(timeout), .resp_r1(resp_r1), .resp_ext(resp_ext), .cs_n(cs_n),
    .spi_data_in(spi_data_in), .spi_bits(spi_bits), .spi_start(spi_start),
    .spi_finished(spi_finished), .spi_data_out(spi_data_out)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // transfers seen by the engine ({bits, data}) and bytes the card will return
  logic [12:0] xq[$];
  logic [7:0]  card_q[$];
  int          done_cnt = 0;
  logic        cap_to;
  logic [7:0]  cap_r1;

  // byte engine + card: random 0-20 cycle latency, occasional stray finish pulses
  initial begin
    bit          eng_out;
    int          eng_cnt;
    logic [12:0] eng_x;
    eng_out = 0;
    eng_cnt = 0;
    eng_x   = '0;
    forever begin
      @(negedge clk);
      spi_finished = 1'b0;
      if (!rst_n) begin
        eng_out = 0;
        continue;
      end
      if (spi_start) begin
        chk("start_while_outstanding", eng_out, 1'b0);
        chk("cs_low_on_start", cs_n, 1'b0);
        eng_x = {spi_bits, spi_data_in};
        xq.push_back(eng_x);
        eng_out = 1;
        eng_cnt = $urandom_range(0, 20);
      end else if (!eng_out && $urandom_range(0, 15) == 0) begin
        spi_finished = 1'b1;
        spi_data_out = 8'h00;
        continue;
      end
      if (eng_out) begin
        if (eng_cnt == 0) begin
          chk("xfer_stable", {spi_bits, spi_data_in}, eng_x);
          spi_data_out = (xq.size() > 6 && card_q.size() > 0) ? card_q.pop_front() : 8'hFF;
          spi_finished = 1'b1;
          eng_out = 0;
        end else eng_cnt--;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        cap_to = timeout;
        cap_r1 = resp_r1;
      end
    end
  end

  // CRC7 as the remainder of frame * x^7 divided by x^7+x^3+1
  function automatic logic [6:0] crc7_ref(input logic [39:0] f);
    logic [46:0] r;
    r = {f, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r = r ^ (47'h89 << (i - 7));
    return r[6:0];
  endfunction

  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic lng,
                         input bit inject, input string nm);
    logic [12:0] ex[$];
    logic [7:0]  cq[$];
    logic [7:0]  b, r1;
    logic [31:0] ext;
    logic        to;
    logic [31:0] fr;
    int          d0, k;
    cq = card_q;
    ex.push_back({5'd7, 2'b01, idx});
    for (int i = 3; i >= 0; i--) begin
      fr = arg >> (8 * i);
      ex.push_back({5'd7, fr[7:0]});
    end
    ex.push_back({5'd7, crc7_ref({2'b01, idx, arg}), 1'b1});
    to = 1'b1; r1 = 8'hFF; ext = 32'h0;
    for (int h = 0; h < HM; h++) begin
      b = (cq.size() > 0) ? cq.pop_front() : 8'hFF;
      ex.push_back({5'd15, 8'hFF});
      if (!b[7]) begin r1 = b; to = 1'b0; break; end
    end
    if (!to && lng)
      for (int i = 0; i < 4; i++) begin
        b = (cq.size() > 0) ? cq.pop_front() : 8'hFF;
        ext = {ext[23:0], b};
        ex.push_back({5'd7, 8'hFF});
      end
    ex.push_back({5'd7, 8'hFF});

    xq.delete();
    d0 = done_cnt;
    @(negedge clk);
    cmd_start = 1'b1; cmd_index = idx; cmd_arg = arg; cmd_long = lng;
    @(negedge clk);
    cmd_start = 1'b0; cmd_index = 6'($urandom); cmd_arg = $urandom; cmd_long = 1'($urandom);
    if (inject) begin
      repeat ($urandom_range(1, 100)) @(negedge clk);
      if (busy) begin
        cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
      end
    end
    k = 0;
    while (done_cnt == d0 && k < 20000) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_done_seen"}, done_cnt != d0, 1'b1);
    repeat (3) @(negedge clk);
    chk({nm, "_done_once"}, done_cnt - d0, 1);
    chk({nm, "_timeout"}, cap_to, to);
    chk({nm, "_r1_at_done"}, cap_r1, r1);
    chk({nm, "_r1"}, resp_r1, r1);
    chk({nm, "_ext"}, resp_ext, ext);
    chk({nm, "_idle"}, {busy, cs_n}, 2'b01);
    chk({nm, "_nxfer"}, xq.size(), ex.size());
    for (int i = 0; i < ex.size() && i < xq.size(); i++)
      chk($sformatf("%s_xfer%0d", nm, i), xq[i], ex[i]);
    card_q.delete();
  endtask

  initial begin
    int d0, k;
    logic [7:0] b;
    repeat (3) @(negedge clk);
    chk("rst_ctl", {cs_n, busy, done, timeout, spi_start}, 5'b10000);
    chk("rst_din", spi_data_in, 8'hFF);
    chk("rst_bits", spi_bits, 5'd0);
    chk("rst_r1", resp_r1, 8'hFF);
    chk("rst_ext", resp_ext, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // CMD0
    card_q = '{8'hFF, 8'h01};
    run_cmd(6'd0, 32'h0, 1'b0, 1'b0, "cmd0");
    if (xq.size() >= 6) chk("cmd0_crc_byte", xq[5][7:0], 8'h95);

    // CMD8 with R7
    card_q = '{8'h01, 8'h00, 8'h00, 8'h01, 8'hAA};
    run_cmd(6'd8, 32'h000001AA, 1'b1, 1'b0, "cmd8");
    if (xq.size() >= 6) chk("cmd8_crc_byte", xq[5][7:0], 8'h87);
    chk("cmd8_ext_const", resp_ext, 32'h000001AA);

    // card silent
    run_cmd(6'd55, 32'h0, 1'b1, 1'b0, "silent");
    chk("silent_timeout", timeout, 1'b1);
    chk("silent_hunts", xq.size(), 6 + HM + 1);

    // busy-time cmd_start is ignored
    card_q = '{8'h05};
    run_cmd(6'd17, 32'hDEADBEEF, 1'b0, 1'b1, "ignore");

    // reset during SEND byte 3
    xq.delete();
    d0 = done_cnt;
    @(negedge clk);
    cmd_start = 1'b1; cmd_index = 6'd24; cmd_arg = 32'h12345678; cmd_long = 1'b0;
    @(negedge clk);
    cmd_start = 1'b0;
    k = 0;
    while (xq.size() < 3 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("mid_reached_byte3", xq.size(), 3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cs", cs_n, 1'b1);
    chk("mid_rst_start", spi_start, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("mid_no_done", done_cnt, d0);
    card_q = '{8'h01};
    run_cmd(6'd0, 32'h0, 1'b0, 1'b0, "after_rst");

    // randomized commands
    for (int t = 0; t < 25; t++) begin
      int npre;
      npre = $urandom_range(0, HM);
      for (int i = 0; i < npre; i++) begin
        b = 8'($urandom) | 8'h80;
        card_q.push_back(b);
      end
      if ($urandom_range(0, 4) != 0) begin
        b = 8'($urandom) & 8'h7F;
        card_q.push_back(b);
      end
      for (int i = 0; i < 4; i++) card_q.push_back(8'($urandom));
      run_cmd(6'($urandom), $urandom, 1'($urandom), 1'($urandom), $sformatf("rnd%0d", t));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
